mem_access_arbiter: RTL and testbench
=====================================

Name: mem_access_arbiter

Overview:
Parametrised N-channel front end for a single-port parameter or intermediate-result memory bank. Round-robin arbitration among requesters, each using a valid/ready handshake. Supports single-width and double-width accesses, a fixed read latency with response routing back to the issuing channel, and automatic power gating of the bank through chip enable with a sleep/wake state machine. Sits between the compute datapath masters and one memory macro wrapper.

Parameters:
NUM_CH, 4, number of requesting channels (2..8)
DATA_W, 16, single-width data bits; double width is 2*DATA_W
ADDR_W, 15, word address width
RD_LAT, 2, memory read latency in cycles, from mem_en to mem_rdata valid (1..4)
IDLE_TIMEOUT, 16, consecutive idle cycles in ACTIVE before chip enable drops
WAKE_CYCLES, 3, cycles chip enable must be high before the first access after sleep

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
ch_req_valid  in  NUM_CH  per-channel request valid
ch_req_ready  out  NUM_CH  per-channel grant; at most one bit high
ch_req_write  in  NUM_CH  1 = write, 0 = read
ch_req_double  in  NUM_CH  1 = double-width access
ch_req_addr  in  NUM_CH*ADDR_W  packed addresses; channel i occupies bits [i*ADDR_W +: ADDR_W]
ch_req_wdata  in  NUM_CH*2*DATA_W  packed write data; single width uses the low DATA_W bits
ch_rsp_valid  out  NUM_CH  one-hot read-response strobe
ch_rsp_data  out  2*DATA_W  shared read-response data
ch_addr_err  out  NUM_CH  sticky misaligned double-access flag
mem_chip_en  out  1  bank power and chip enable
mem_en  out  1  access strobe
mem_write  out  1  access is a write
mem_double  out  1  access is double width
mem_addr  out  ADDR_W  access address
mem_wdata  out  2*DATA_W  write data
mem_rdata  in  2*DATA_W  read data, valid RD_LAT cycles after a read mem_en

Behaviour:
- Reset state: all outputs 0, except mem_chip_en = 1. State = ACTIVE, RR pointer = 0, idle counter = 0, in-flight pipeline cleared, ch_addr_err cleared.
- Reset mid-operation: in-flight reads are dropped and produce no response.
- States:
  - ACTIVE: grants allowed.
  - SLEEP: mem_chip_en = 0, no grants.
  - WAKE: mem_chip_en = 1, no grants, wake counter runs.
- Transitions:
  - ACTIVE -> SLEEP: after IDLE_TIMEOUT consecutive cycles with no valid request and no read in flight.
  - SLEEP -> WAKE: on the cycle any ch_req_valid is high.
  - WAKE -> ACTIVE: after WAKE_CYCLES cycles in WAKE.
  - The idle counter resets on any valid request or grant.
- Arbitration (ACTIVE only):
  - ch_req_ready is combinational from ch_req_valid and the RR pointer.
  - The first valid channel at or after the pointer wins.
  - On a grant, the pointer becomes (winner+1) mod NUM_CH. With no grant, the pointer holds.
  - One grant per cycle. A transfer occurs when valid and ready are both high.
- Issue:
  - mem_en, mem_write, mem_double, mem_addr and mem_wdata are registered and asserted the cycle after the transfer (1 cycle issue latency).
  - mem_wdata is 0 for reads. When no access is issued, mem_en = 0 and all other mem_* outputs except mem_chip_en are 0.
- Misalignment:
  - Double access with an odd address: the request is granted but no mem_en is issued, and ch_addr_err[i] is set. The flag clears only on reset.
  - A misaligned read still returns a response with data 0 at the normal latency, so requesters never hang.
- Response:
  - A read transferred at cycle t gives ch_rsp_valid[i] = 1 at cycle t+1+RD_LAT.
  - ch_rsp_data = mem_rdata. For single-width reads the upper DATA_W bits are forced to 0.
  - A pipeline of depth RD_LAT carries {valid, channel, double, err}. Back-to-back reads from different channels return in issue order, one per cycle.
  - ch_rsp_data is 0 when no response is valid.
- Writes produce no response.
- Read-after-write ordering to the same address follows issue order. The arbiter does no forwarding.
- Simultaneous events: a request arriving on the cycle the idle counter would expire keeps the state in ACTIVE and the request is granted.

Test Plan:
- Reset with ch_req_valid=4'b1111 held -> grants ch0, ch1, ch2, ch3, ch0 on consecutive cycles; mem_en high from the cycle after the first grant.
- ch2 single read, addr 0x10, mem_rdata=0xABCD1234 at RD_LAT=2 -> ch_rsp_valid=4'b0100 exactly 3 cycles after the transfer; ch_rsp_data=0x00001234.
- ch1 double write, addr 0x7 -> ready high, no mem_en, ch_addr_err=4'b0010 stays set. ch1 double read at 0x7 -> response data 0 at normal latency.
- No requests for 16 cycles -> mem_chip_en=0. Request on ch3 -> mem_chip_en=1 next cycle; grant exactly WAKE_CYCLES=3 cycles later.
- Reads from ch0 then ch3 back-to-back, then assert rst between issue and response -> no ch_rsp_valid pulses; all outputs at their reset values.

Source files
------------

// File: rtl/mem_access_arbiter.sv
`default_nettype none
// ============================================================================
// mem_access_arbiter: round-robin N-channel front end for one memory bank
// Rev 1.0 - read-response routing, misalignment flags, chip-enable gating
// ============================================================================
module mem_access_arbiter #(
  parameter int NUM_CH       = 4,
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 15,
  parameter int RD_LAT       = 2,
  parameter int IDLE_TIMEOUT = 16,
  parameter int WAKE_CYCLES  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          ch_req_valid,
  output logic [NUM_CH-1:0]          ch_req_ready,
  input  logic [NUM_CH-1:0]          ch_req_write,
  input  logic [NUM_CH-1:0]          ch_req_double,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_req_addr,
  input  logic [NUM_CH*2*DATA_W-1:0] ch_req_wdata,
  output logic [NUM_CH-1:0]          ch_rsp_valid,
  output logic [2*DATA_W-1:0]        ch_rsp_data,
  output logic [NUM_CH-1:0]          ch_addr_err,
  output logic                       mem_chip_en,
  output logic                       mem_en,
  output logic                       mem_write,
  output logic                       mem_double,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [2*DATA_W-1:0]        mem_wdata,
  input  logic [2*DATA_W-1:0]        mem_rdata
);

  localparam int C_CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int C_SUM_W   = C_CH_W + 1;
  localparam int C_CNT_MAX = (IDLE_TIMEOUT > WAKE_CYCLES) ? IDLE_TIMEOUT : WAKE_CYCLES;
  localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_SLEEP  = 2'd1,
    ST_WAKE   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [C_CNT_W-1:0]   cnt_q, cnt_d;
  logic [C_CH_W-1:0]    ptr_q, ptr_d;

  logic                 any_valid, found, grant_en, xfer, misalign, in_flight;
  logic [C_CH_W-1:0]    win;
  logic [C_SUM_W-1:0]   sum;

  logic                 sel_write, sel_double;
  logic [ADDR_W-1:0]    sel_addr;
  logic [2*DATA_W-1:0]  sel_wdata;

  logic                 mem_en_q, mem_write_q, mem_double_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic [2*DATA_W-1:0]  mem_wdata_q;
  logic [NUM_CH-1:0]    err_q;

  // Read tag pipeline: stage 0 is the issue cycle, stage RD_LAT lines up with mem_rdata.
  logic [RD_LAT:0]              pv_q, pdbl_q, perr_q;
  logic [RD_LAT:0][C_CH_W-1:0]  pch_q;

  assign any_valid = |ch_req_valid;
  assign grant_en  = (state_q == ST_ACTIVE) && !rst;
  assign in_flight = |pv_q;

  always_comb begin
    found        = 1'b0;
    win          = '0;
    sum          = '0;
    ch_req_ready = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum = {1'b0, ptr_q} + C_SUM_W'(k);
      if (sum >= C_SUM_W'(NUM_CH)) begin
        sum = sum - C_SUM_W'(NUM_CH);
      end
      if (!found && ch_req_valid[sum[C_CH_W-1:0]]) begin
        found = 1'b1;
        win   = sum[C_CH_W-1:0];
      end
    end
    if (found && grant_en) begin
      ch_req_ready[win] = 1'b1;
    end
  end

  assign xfer = found && grant_en;

  always_comb begin
    sel_write  = 1'b0;
    sel_double = 1'b0;
    sel_addr   = '0;
    sel_wdata  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (C_CH_W'(k) == win) begin
        sel_write  = ch_req_write[k];
        sel_double = ch_req_double[k];
        sel_addr   = ch_req_addr[k*ADDR_W +: ADDR_W];
        sel_wdata  = ch_req_wdata[k*2*DATA_W +: 2*DATA_W];
      end
    end
  end

  assign misalign = xfer && sel_double && sel_addr[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACTIVE;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    mem_chip_en = (state_q != ST_SLEEP);
    if (xfer) begin
      ptr_d = (win == C_CH_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
    end
    case (state_q)
      ST_ACTIVE: begin
        // A request on the expiry cycle counts as activity, so the bank stays up.
        if (any_valid || in_flight) begin
          cnt_d = '0;
        end else if (cnt_q == C_CNT_W'(IDLE_TIMEOUT - 1)) begin
          state_d = ST_SLEEP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SLEEP: begin
        if (any_valid) begin
          state_d = ST_WAKE;
          cnt_d   = '0;
        end
      end
      ST_WAKE: begin
        if (cnt_q == C_CNT_W'(WAKE_CYCLES - 1)) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_ACTIVE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en_q     <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_double_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      err_q        <= '0;
      pv_q         <= '0;
      pdbl_q       <= '0;
      perr_q       <= '0;
      pch_q        <= '0;
    end else begin
      mem_en_q     <= xfer && !misalign;
      mem_write_q  <= xfer && !misalign && sel_write;
      mem_double_q <= xfer && !misalign && sel_double;
      mem_addr_q   <= (xfer && !misalign) ? sel_addr : '0;
      if (xfer && !misalign && sel_write) begin
        mem_wdata_q <= sel_double ? sel_wdata : {{DATA_W{1'b0}}, sel_wdata[DATA_W-1:0]};
      end else begin
        mem_wdata_q <= '0;
      end
      err_q  <= err_q | (ch_req_ready & {NUM_CH{misalign}});
      pv_q   <= {pv_q[RD_LAT-1:0], xfer && !sel_write};
      pdbl_q <= {pdbl_q[RD_LAT-1:0], sel_double};
      perr_q <= {perr_q[RD_LAT-1:0], misalign};
      pch_q  <= {pch_q[RD_LAT-1:0], win};
    end
  end

  assign mem_en      = mem_en_q;
  assign mem_write   = mem_write_q;
  assign mem_double  = mem_double_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign ch_addr_err = err_q;

  // Misaligned reads never reached the bank, so they answer with zero data.
  always_comb begin
    ch_rsp_valid = '0;
    ch_rsp_data  = '0;
    if (pv_q[RD_LAT]) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (pch_q[RD_LAT] == C_CH_W'(k)) begin
          ch_rsp_valid[k] = 1'b1;
        end
      end
      if (!perr_q[RD_LAT]) begin
        ch_rsp_data = pdbl_q[RD_LAT] ? mem_rdata : {{DATA_W{1'b0}}, mem_rdata[DATA_W-1:0]};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_access_arbiter: directed scoreboard bench for mem_access_arbiter
// Rev 1.0
// ============================================================================
module tb_mem_access_arbiter;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 15;
  localparam int RD_LAT = 2;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic [NUM_CH-1:0]          ch_req_valid = '0;
  logic [NUM_CH-1:0]          ch_req_ready;
  logic [NUM_CH-1:0]          ch_req_write = '0;
  logic [NUM_CH-1:0]          ch_req_double = '0;
  logic [NUM_CH*ADDR_W-1:0]   ch_req_addr = '0;
  logic [NUM_CH*2*DATA_W-1:0] ch_req_wdata = '0;
  logic [NUM_CH-1:0]          ch_rsp_valid;
  logic [2*DATA_W-1:0]        ch_rsp_data;
  logic [NUM_CH-1:0]          ch_addr_err;
  logic                       mem_chip_en, mem_en, mem_write, mem_double;
  logic [ADDR_W-1:0]          mem_addr;
  logic [2*DATA_W-1:0]        mem_wdata;
  logic [2*DATA_W-1:0]        mem_rdata = 32'hDEADBEEF;

  mem_access_arbiter #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT),
    .IDLE_TIMEOUT(16), .WAKE_CYCLES(3)
  ) dut (
    .clk(clk), .rst(rst),
    .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready),
    .ch_req_write(ch_req_write), .ch_req_double(ch_req_double),
    .ch_req_addr(ch_req_addr), .ch_req_wdata(ch_req_wdata),
    .ch_rsp_valid(ch_rsp_valid), .ch_rsp_data(ch_rsp_data),
    .ch_addr_err(ch_addr_err), .mem_chip_en(mem_chip_en),
    .mem_en(mem_en), .mem_write(mem_write), .mem_double(mem_double),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          ch;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Bank model: fixed read latency, garbage on the data bus when nothing is due.
  bit   [31:0] mem [0:32767];
  logic [31:0] rq [RD_LAT];
  bit          rv [RD_LAT];
  initial begin
    for (int s = 0; s < RD_LAT; s++) begin
      rq[s] = '0;
      rv[s] = 1'b0;
    end
  end
  always @(posedge clk) begin
    for (int s = RD_LAT - 1; s > 0; s--) begin
      rq[s] = rq[s-1];
      rv[s] = rv[s-1];
    end
    rq[0] = mem[mem_addr];
    rv[0] = mem_en && !mem_write;
    if (mem_en && mem_write) begin
      if (mem_double) mem[mem_addr] = mem_wdata;
      else            mem[mem_addr][15:0] = mem_wdata[15:0];
    end
    mem_rdata = rv[RD_LAT-1] ? rq[RD_LAT-1] : 32'hDEADBEEF;
  end

  // Response monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ch_rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", {60'h0, ch_rsp_valid}, 64'h0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_valid", {60'h0, ch_rsp_valid}, 64'(4'b0001 << e.ch));
          check("rsp_data", {32'h0, ch_rsp_data}, {32'h0, e.data});
          check("rsp_cycle", 64'(cyc), 64'(e.due));
        end
      end else begin
        check("rsp_data_idle", {32'h0, ch_rsp_data}, 64'h0);
      end
    end
  end

  task automatic issue(input int ch, input bit wr, input bit dbl, input logic [14:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rsp, output int xcyc);
    int  n;
    bit  got;
    bit  en_exp;
    n    = 0;
    got  = 1'b0;
    xcyc = -1;
    @(posedge clk); #1;
    ch_req_write[ch]               = wr;
    ch_req_double[ch]              = dbl;
    ch_req_addr[ch*ADDR_W +: ADDR_W] = addr;
    ch_req_wdata[ch*32 +: 32]      = wd;
    ch_req_valid[ch]               = 1'b1;
    while (!got && n < 20) begin
      @(negedge clk);
      if (ch_req_ready[ch]) got = 1'b1;
      else n++;
    end
    check("grant", 64'(got), 64'h1);
    if (got) begin
      xcyc = cyc;
      if (!wr) exp_q.push_back('{ch, exp_rsp, cyc + 1 + RD_LAT});
    end
    @(posedge clk); #1;
    ch_req_valid[ch] = 1'b0;
    @(negedge clk);
    en_exp = got && !(dbl && addr[0]);
    check("mem_en", 64'(mem_en), 64'(en_exp));
    check("mem_write", 64'(mem_write), 64'(en_exp && wr));
    check("mem_double", 64'(mem_double), 64'(en_exp && dbl));
    check("mem_addr", 64'(mem_addr), en_exp ? 64'(addr) : 64'h0);
    check("mem_wdata", 64'(mem_wdata),
          (en_exp && wr) ? (dbl ? 64'(wd) : 64'(wd[15:0])) : 64'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(ch_req_ready), 64'h0);
    check({tag, "_rsp_valid"}, 64'(ch_rsp_valid), 64'h0);
    check({tag, "_addr_err"}, 64'(ch_addr_err), 64'h0);
    check({tag, "_chip_en"}, 64'(mem_chip_en), 64'h1);
    check({tag, "_mem_en"}, 64'(mem_en), 64'h0);
    check({tag, "_mem_ctrl"}, {62'h0, mem_write, mem_double}, 64'h0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'h0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int x, s;
    logic [3:0] exp_rdy [5];
    exp_rdy[0] = 4'b0001; exp_rdy[1] = 4'b0010; exp_rdy[2] = 4'b0100;
    exp_rdy[3] = 4'b1000; exp_rdy[4] = 4'b0001;
    mem[0]    = 32'h5555AAAA;
    mem[16]   = 32'hABCD1234;

    // Reset held with all channels requesting reads at address 0
    ch_req_valid = 4'b1111;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst0");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rr_grant", 64'(ch_req_ready), 64'(exp_rdy[i]));
      check("rr_mem_en", 64'(mem_en), (i >= 1) ? 64'h1 : 64'h0);
      exp_q.push_back('{i % NUM_CH, 32'h0000AAAA, cyc + 1 + RD_LAT});
      if (i < 4) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    ch_req_valid = '0;
    repeat (6) @(negedge clk);

    // Single read routing and upper-half masking
    issue(2, 1'b0, 1'b0, 15'h10, 32'h0, 32'h00001234, x);
    // Writes followed by reads of the written data
    issue(0, 1'b1, 1'b1, 15'h20, 32'h11112222, 32'h0, x);
    issue(1, 1'b0, 1'b0, 15'h20, 32'h0, 32'h00002222, x);
    issue(3, 1'b0, 1'b1, 15'h20, 32'h0, 32'h11112222, x);
    issue(2, 1'b1, 1'b0, 15'h21, 32'hFFFF5678, 32'h0, x);
    issue(2, 1'b0, 1'b0, 15'h21, 32'h0, 32'h00005678, x);
    repeat (4) @(negedge clk);

    // Misaligned double accesses
    check("err_clear", 64'(ch_addr_err), 64'h0);
    issue(1, 1'b1, 1'b1, 15'h7, 32'hCAFEF00D, 32'h0, x);
    check("err_set", 64'(ch_addr_err), 64'h2);
    issue(1, 1'b0, 1'b1, 15'h7, 32'h0, 32'h0, x);
    repeat (4) @(negedge clk);
    check("err_sticky", 64'(ch_addr_err), 64'h2);

    // Idle timeout into sleep
    repeat (8) @(negedge clk);
    issue(0, 1'b1, 1'b0, 15'h30, 32'h00001234, 32'h0, x);
    repeat (15) @(negedge clk);
    check("chip_en_before_timeout", 64'(mem_chip_en), 64'h1);
    @(negedge clk);
    check("chip_en_sleep", 64'(mem_chip_en), 64'h0);
    repeat (2) @(negedge clk);

    // Wake on a ch3 read
    @(posedge clk); #1;
    ch_req_write[3] = 1'b0;
    ch_req_double[3] = 1'b0;
    ch_req_addr[3*ADDR_W +: ADDR_W] = 15'h10;
    ch_req_valid[3] = 1'b1;
    s = cyc;
    @(negedge clk);
    check("sleep_chip_en", 64'(mem_chip_en), 64'h0);
    check("sleep_no_grant", 64'(ch_req_ready), 64'h0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("wake_chip_en", 64'(mem_chip_en), 64'h1);
      check("wake_no_grant", 64'(ch_req_ready), 64'h0);
    end
    @(negedge clk);
    check("wake_grant", 64'(ch_req_ready), 64'h8);
    check("wake_grant_cycle", 64'(cyc - s), 64'h4);
    if (ch_req_ready[3]) exp_q.push_back('{3, 32'h00001234, cyc + 1 + RD_LAT});
    @(posedge clk); #1;
    ch_req_valid = '0;
    repeat (6) @(negedge clk);

    // Back-to-back reads, then reset before their responses
    @(posedge clk); #1;
    ch_req_write = '0;
    ch_req_double = '0;
    ch_req_addr[0 +: ADDR_W] = 15'h10;
    ch_req_addr[3*ADDR_W +: ADDR_W] = 15'h0;
    ch_req_valid = 4'b1001;
    @(negedge clk);
    check("b2b_grant0", 64'(ch_req_ready), 64'h1);
    @(posedge clk); #1;
    ch_req_valid[0] = 1'b0;
    @(negedge clk);
    check("b2b_grant3", 64'(ch_req_ready), 64'h8);
    check("b2b_mem_en", 64'(mem_en), 64'h1);
    @(posedge clk); #1;
    ch_req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst1");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("post_rst_err", 64'(ch_addr_err), 64'h0);
    check("post_rst_chip_en", 64'(mem_chip_en), 64'h1);
    check("queue_empty", 64'(exp_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
